// File: rtl/mnist_256to1pix.sv
// Downscales a square grayscale raster stream by averaging each 2^BLK_LOG2 square
// block of input pixels into one output pixel, emitted in raster order.
module mnist_256to1pix #(
   parameter int IMG_IN   = 448,
   parameter int BLK_LOG2 = 4,
   parameter int IMG_OUT  = IMG_IN >> BLK_LOG2
) (
   input  logic       cmos_pclk,
   input  logic       rst_n,
   input  logic       mnist_data_valid,
   input  logic [7:0] mnist_data,
   input  logic       mnist_start,
   output logic       mnist_data_valid_norm,
   output logic [7:0] mnist_data_norm
);

   localparam int CW = $clog2(IMG_IN);
   localparam int AW = 2 * BLK_LOG2 + 8;
   localparam int BW = (IMG_OUT > 1) ? $clog2(IMG_OUT) : 1;

   // Handshake: mnist_data_valid qualifies one pixel per cycle with no back-pressure;
   // mnist_data_valid_norm is a one-cycle pulse and mnist_data_norm holds between pulses.

   logic [CW-1:0] h;
   logic [CW-1:0] v;
   logic [AW-1:0] acc [IMG_OUT];

   logic [BW-1:0] col;
   logic [AW-1:0] sum;
   logic          h_last;
   logic          v_last;
   logic          blk_done;

   assign col      = BW'(h >> BLK_LOG2);
   assign sum      = acc[col] + AW'(mnist_data);
   assign h_last   = (h == CW'(IMG_IN - 1));
   assign v_last   = (v == CW'(IMG_IN - 1));
   assign blk_done = mnist_data_valid && (&h[BLK_LOG2-1:0]) && (&v[BLK_LOG2-1:0]);

   // Output stage: the completing beat is folded into the sum directly, so the mean
   // is available one cycle later without waiting for the accumulator write.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         mnist_data_valid_norm <= 1'b0;
         mnist_data_norm       <= 8'd0;
      end else begin
         mnist_data_valid_norm <= blk_done;
         if (blk_done) begin
            mnist_data_norm <= sum[AW-1 -: 8];
         end
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (mnist_start) begin
         h <= '0;
         v <= '0;
      end else if (mnist_data_valid) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + CW'(1);
         end else begin
            h <= h + CW'(1);
         end
      end
   end

   // A completing beat clears its column so the next block row starts from zero.
   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IMG_OUT; i++) begin
            acc[i] <= '0;
         end
      end else if (mnist_start) begin
         for (int i = 0; i < IMG_OUT; i++) begin
            acc[i] <= '0;
         end
      end else if (mnist_data_valid) begin
         acc[col] <= blk_done ? '0 : sum;
      end
   end

endmodule

// File: tb/tb_mnist_256to1pix.sv
// Bench for mnist_256to1pix on a reduced 48x48 frame (3x3 output); expected pulses and
// means come from block sums over the frame image held in the bench.
module tb_mnist_256to1pix;

   localparam int IMG_IN   = 48;
   localparam int BLK_LOG2 = 4;
   localparam int IMG_OUT  = 3;
   localparam int BLK      = 16;
   localparam int N_BEATS  = IMG_IN * IMG_IN;

   logic       cmos_pclk = 1'b0;
   logic       rst_n;
   logic       mnist_data_valid;
   logic [7:0] mnist_data;
   logic       mnist_start;
   logic       mnist_data_valid_norm;
   logic [7:0] mnist_data_norm;

   always #5 cmos_pclk = ~cmos_pclk;

   mnist_256to1pix #(
      .IMG_IN   (IMG_IN),
      .BLK_LOG2 (BLK_LOG2),
      .IMG_OUT  (IMG_OUT)
   ) dut (
      .cmos_pclk             (cmos_pclk),
      .rst_n                 (rst_n),
      .mnist_data_valid      (mnist_data_valid),
      .mnist_data            (mnist_data),
      .mnist_start           (mnist_start),
      .mnist_data_valid_norm (mnist_data_valid_norm),
      .mnist_data_norm       (mnist_data_norm)
   );

   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] img [IMG_IN][IMG_IN];
   int         px = 0;
   int         py = 0;
   logic [7:0] last_norm = 8'd0;
   int         pulses_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h (pixel x=%0d y=%0d)", tag, obs, exp, px, py);
      end
   endtask

   function automatic logic [7:0] blk_mean(input int bx, input int by);
      int s;
      s = 0;
      for (int y = 0; y < BLK; y++)
         for (int x = 0; x < BLK; x++)
            s += int'(img[by*BLK + y][bx*BLK + x]);
      return 8'(s / (BLK * BLK));
   endfunction

   task automatic fill(input int mode);
      logic [7:0] rom [IMG_OUT][IMG_OUT];
      for (int by = 0; by < IMG_OUT; by++)
         for (int bx = 0; bx < IMG_OUT; bx++)
            rom[by][bx] = 8'($urandom);
      for (int y = 0; y < IMG_IN; y++) begin
         for (int x = 0; x < IMG_IN; x++) begin
            case (mode)
               0: img[y][x] = 8'd255;
               1: img[y][x] = rom[y/BLK][x/BLK];
               default: img[y][x] = 8'($urandom);
            endcase
            if (mode == 3 && y < BLK && x < BLK)
               img[y][x] = (((y*BLK + x) % 2) == 0) ? 8'd255 : 8'd0;
            if (mode == 3 && y < BLK && x >= BLK && x < 2*BLK)
               img[y][x] = (x == BLK && y == 0) ? 8'd0 : 8'd1;
         end
      end
   endtask

   task automatic cycle(input logic v_in, input logic s_in);
      logic       exp_v;
      @(negedge cmos_pclk);
      mnist_data_valid = v_in;
      mnist_data       = v_in ? img[py][px] : 8'($urandom);
      mnist_start      = s_in;
      exp_v = v_in && (px % BLK == BLK - 1) && (py % BLK == BLK - 1);
      if (exp_v) last_norm = blk_mean(px / BLK, py / BLK);
      if (v_in) begin
         px++;
         if (px == IMG_IN) begin
            px = 0;
            py = (py == IMG_IN - 1) ? 0 : py + 1;
         end
      end
      if (s_in) begin
         px = 0;
         py = 0;
      end
      @(posedge cmos_pclk);
      #1;
      if (mnist_data_valid_norm === 1'b1) pulses_seen++;
      check("valid_norm", 32'(mnist_data_valid_norm), 32'(exp_v));
      check("data_norm", 32'(mnist_data_norm), 32'(last_norm));
   endtask

   task automatic run_beats(input int n, input int min_gap, input int max_gap, input bit start_last);
      int g;
      for (int i = 0; i < n; i++) begin
         g = int'($urandom_range(max_gap, min_gap));
         repeat (g) cycle(1'b0, 1'b0);
         cycle(1'b1, start_last && (i == n - 1));
      end
   endtask

   task automatic full_frame(input int mode, input int min_gap, input int max_gap,
                             input bit start_last);
      fill(mode);
      pulses_seen = 0;
      run_beats(N_BEATS, min_gap, max_gap, start_last);
      check("pulse_count", 32'(pulses_seen), 32'(IMG_OUT * IMG_OUT));
   endtask

   task automatic apply_reset();
      @(posedge cmos_pclk);
      #2;
      rst_n = 1'b0;
      mnist_data_valid = 1'b0;
      mnist_start = 1'b0;
      #1;
      check("async_rst_valid", 32'(mnist_data_valid_norm), 32'd0);
      check("async_rst_data", 32'(mnist_data_norm), 32'd0);
      px = 0;
      py = 0;
      last_norm = 8'd0;
      repeat (2) @(negedge cmos_pclk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n            = 1'b0;
      mnist_data_valid = 1'b0;
      mnist_data       = 8'd0;
      mnist_start      = 1'b0;
      repeat (3) @(negedge cmos_pclk);
      check("reset_valid", 32'(mnist_data_valid_norm), 32'd0);
      check("reset_data", 32'(mnist_data_norm), 32'd0);
      rst_n = 1'b1;
      repeat (3) cycle(1'b0, 1'b0);

      // All-255 frame with a beat every other cycle.
      full_frame(0, 1, 1, 1'b0);
      // Block-replicated image with random gaps.
      full_frame(1, 0, 3, 1'b0);
      // Random pixels, back-to-back beats.
      full_frame(2, 0, 0, 1'b0);
      // Half-255/half-0 block and 255-ones-one-zero block for floor rounding.
      full_frame(3, 0, 2, 1'b0);
      // Start coincident with the last beat, then a clean frame.
      full_frame(2, 0, 2, 1'b1);
      full_frame(2, 0, 1, 1'b0);

      // Reset mid-frame, then a full frame.
      fill(2);
      run_beats(IMG_IN * 33 + 5, 0, 1, 1'b0);
      apply_reset();
      full_frame(2, 0, 1, 1'b0);

      // Standalone start mid-block, then a full frame.
      fill(2);
      run_beats(IMG_IN * 17 + 20, 0, 1, 1'b0);
      cycle(1'b0, 1'b1);
      full_frame(1, 0, 1, 1'b0);

      // Start coincident with a mid-block beat, then a full frame.
      fill(2);
      run_beats(IMG_IN * 5 + 3, 0, 1, 1'b1);
      full_frame(2, 0, 1, 1'b0);

      repeat (5) cycle(1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
